circuito_exp3_desafio: RTL and testbench
========================================

CIRCUITO_EXP3_DESAFIO -- requirements
Module: circuito_exp3_desafio

Interface
REQ-001 SHALL have port `clock`: input, 1 bit, sole clock, rising-edge active.
REQ-002 SHALL have port `reset`: input, 1 bit, asynchronous, active-low.
REQ-003 SHALL have port `iniciar`: input, 1 bit, start/restart request, sampled on clock.
REQ-004 SHALL have port `chaves`: input, 4 bits, player's key value.
REQ-005 SHALL have port `pronto`: output, 1 bit, high in either end state.
REQ-006 SHALL have port `acertou`: output, 1 bit, high in FIM_ACERTO only.
REQ-007 SHALL have port `errou`: output, 1 bit, high in FIM_ERRO only.
REQ-008 SHALL have port `db_igual`: output, 1 bit, comparator result (stored keys == memory word).
REQ-009 SHALL have port `db_iniciar`: output, 1 bit, direct copy of `iniciar`.
REQ-010 SHALL have ports `db_contagem`, `db_memoria`, `db_chaves`, `db_estado`: outputs, 7 bits each, seven-segment hex of address counter, memory word, stored keys and state code.
REQ-011 SHALL have port `db_acertou_errou`: output, 7 bits, seven-segment glyph "A" in FIM_ACERTO, "E" in FIM_ERRO, all segments off otherwise.

Function
REQ-012 Seven-segment encoding SHALL be bit order gfedcba, active-low (0 = segment lit), hex digits 0-F.
REQ-013 Memory SHALL be a 16x4 combinational ROM addressed by a 4-bit counter.
REQ-014 ROM contents, addresses 0-15, SHALL be: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4.
REQ-015 The keys register SHALL be 4 bits and SHALL load `chaves` only in REGISTRA.
REQ-016 The counter SHALL be 4 bits, SHALL clear in PREPARACAO, SHALL increment in PROXIMO, and SHALL assert `fim` at value 15.
REQ-017 The FSM SHALL be Moore, with states and 4-bit codes: INICIAL=0, PREPARACAO=1, REGISTRA=2, COMPARACAO=3, PROXIMO=4, FIM_ACERTO=A, FIM_ERRO=E.
REQ-018 INICIAL SHALL go to PREPARACAO if `iniciar`=1, else stay in INICIAL.
REQ-019 PREPARACAO SHALL go to REGISTRA unconditionally.
REQ-020 REGISTRA SHALL go to COMPARACAO unconditionally.
REQ-021 COMPARACAO SHALL go to FIM_ERRO if not igual; to FIM_ACERTO if igual and fim; otherwise to PROXIMO.
REQ-022 PROXIMO SHALL go to REGISTRA.
REQ-023 FIM_ACERTO and FIM_ERRO SHALL go to PREPARACAO if `iniciar`=1, else hold.
REQ-024 Counter and keys register SHALL hold their values in the end states, so the displays freeze on the final step.
REQ-025 Latency: one step SHALL be 3 clocks (REGISTRA, COMPARACAO, PROXIMO). A full correct run SHALL take 48 clocks from the PREPARACAO entry to FIM_ACERTO (16 REGISTRA, 16 COMPARACAO and 15 PROXIMO cycles plus 1 PREPARACAO).
REQ-026 `iniciar` SHALL be ignored in PREPARACAO, REGISTRA, COMPARACAO and PROXIMO.
REQ-027 `db_estado` SHALL display the current state code.
REQ-028 `db_igual` SHALL be purely combinational.

Reset
REQ-029 `reset`=0 SHALL asynchronously force state INICIAL, counter 0 and keys register 0.
REQ-030 While in reset, outputs SHALL be: `pronto`=`acertou`=`errou`=0; `db_estado`, `db_contagem`, `db_chaves` show "0"; `db_memoria` shows "1"; `db_acertou_errou` blank.
REQ-031 Reset asserted mid-run SHALL abort the run immediately; no end flag is asserted.

Structure
REQ-032 A shared package SHALL hold the state codes, the ROM contents and the segment patterns.
REQ-033 One sub-module `hexa7seg` (4-bit to 7-segment decoder) SHALL be instantiated five times.
REQ-034 Counter, register, comparator, ROM and FSM SHALL be inline.

Verification
REQ-035 Reset low, then high, `iniciar`=0 for 5 clocks -> `db_estado`="0", `pronto`=0.
REQ-036 `iniciar` pulse, `chaves` tracking the ROM word at each REGISTRA -> FIM_ACERTO after 48 clocks, `acertou`=1, `pronto`=1, `db_contagem`="F", `db_acertou_errou`="A".
REQ-037 `iniciar` pulse with `chaves`=0000 -> FIM_ERRO on the 4th clock edge, `errou`=1, `db_contagem`="0", `db_acertou_errou`="E".
REQ-038 Correct keys for addresses 0-5, then 0000 at address 6 -> FIM_ERRO, `db_contagem`="6", `db_memoria`="1", `db_chaves`="0".
REQ-039 `iniciar` in FIM_ERRO -> PREPARACAO, counter 0, flags low.
REQ-040 Reset during PROXIMO at address 9 -> immediate INICIAL, counter 0.

Source files
------------

// File: rtl/circuito_exp3_desafio_pkg.sv
// Shared definitions for the memory-matching game: state codes, ROM contents
// and seven-segment glyphs (gfedcba, active-low).
package circuito_exp3_desafio_pkg;

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        REGISTRA   = 4'h2,
        COMPARACAO = 4'h3,
        PROXIMO    = 4'h4,
        FIM_ACERTO = 4'hA,
        FIM_ERRO   = 4'hE
    } estado_t;

    localparam logic [3:0] ULTIMO_ENDERECO = 4'hF;
    localparam logic [6:0] SEG_APAGADO     = 7'b1111111;

    function automatic logic [3:0] rom_palavra(input logic [3:0] endereco);
        logic [3:0] palavra;
        case (endereco)
            4'h0: palavra = 4'b0001;
            4'h1: palavra = 4'b0010;
            4'h2: palavra = 4'b0100;
            4'h3: palavra = 4'b1000;
            4'h4: palavra = 4'b0100;
            4'h5: palavra = 4'b0010;
            4'h6: palavra = 4'b0001;
            4'h7: palavra = 4'b0001;
            4'h8: palavra = 4'b0010;
            4'h9: palavra = 4'b0010;
            4'hA: palavra = 4'b0100;
            4'hB: palavra = 4'b0100;
            4'hC: palavra = 4'b1000;
            4'hD: palavra = 4'b1000;
            4'hE: palavra = 4'b0001;
            default: palavra = 4'b0100;
        endcase
        return palavra;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] valor);
        logic [6:0] padrao;
        case (valor)
            4'h0: padrao = 7'b1000000;
            4'h1: padrao = 7'b1111001;
            4'h2: padrao = 7'b0100100;
            4'h3: padrao = 7'b0110000;
            4'h4: padrao = 7'b0011001;
            4'h5: padrao = 7'b0010010;
            4'h6: padrao = 7'b0000010;
            4'h7: padrao = 7'b1111000;
            4'h8: padrao = 7'b0000000;
            4'h9: padrao = 7'b0010000;
            4'hA: padrao = 7'b0001000;
            4'hB: padrao = 7'b0000011;
            4'hC: padrao = 7'b1000110;
            4'hD: padrao = 7'b0100001;
            4'hE: padrao = 7'b0000110;
            default: padrao = 7'b0001110;
        endcase
        return padrao;
    endfunction

endpackage

// File: rtl/circuito_exp3_desafio_hexa7seg.sv
// Hex digit to seven-segment decoder (gfedcba, active-low).
module hexa7seg
    import circuito_exp3_desafio_pkg::*;
(
    input  logic [3:0] hexa,
    output logic [6:0] display
);

    assign display = seg7(hexa);

endmodule

// File: rtl/circuito_exp3_desafio.sv
// Memory game: the player must match a 16-word ROM sequence one key value
// at a time; a Moore FSM steps through register / compare / next phases.
module circuito_exp3_desafio
    import circuito_exp3_desafio_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_igual,
    output logic       db_iniciar,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_chaves,
    output logic [6:0] db_estado,
    output logic [6:0] db_acertou_errou
);

    estado_t    estado_q, estado_d;
    logic [3:0] contagem_q, contagem_d;
    logic [3:0] chaves_q, chaves_d;
    logic [3:0] memoria;
    logic       fim;
    logic       igual;

    assign memoria = rom_palavra(contagem_q);
    assign fim     = (contagem_q == ULTIMO_ENDERECO);
    assign igual   = (chaves_q == memoria);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            contagem_q <= '0;
            chaves_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            contagem_q <= contagem_d;
            chaves_q   <= chaves_d;
        end
    end

    // Counter and keys only move in their own states, so both freeze in the end states.
    always_comb begin
        estado_d   = estado_q;
        contagem_d = contagem_q;
        chaves_d   = chaves_q;
        pronto     = 1'b0;
        acertou    = 1'b0;
        errou      = 1'b0;
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                contagem_d = '0;
                estado_d   = REGISTRA;
            end
            REGISTRA: begin
                chaves_d = chaves;
                estado_d = COMPARACAO;
            end
            COMPARACAO: begin
                if (!igual)   estado_d = FIM_ERRO;
                else if (fim) estado_d = FIM_ACERTO;
                else          estado_d = PROXIMO;
            end
            PROXIMO: begin
                contagem_d = contagem_q + 4'd1;
                estado_d   = REGISTRA;
            end
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                if (iniciar) estado_d = PREPARACAO;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
                if (iniciar) estado_d = PREPARACAO;
            end
            default: estado_d = INICIAL;
        endcase
    end

    assign db_igual   = igual;
    assign db_iniciar = iniciar;

    // The end-state codes A and E double as the result glyphs.
    logic [3:0] hexa_in  [5];
    logic [6:0] hexa_out [5];

    assign hexa_in[0] = contagem_q;
    assign hexa_in[1] = memoria;
    assign hexa_in[2] = chaves_q;
    assign hexa_in[3] = estado_q;
    assign hexa_in[4] = estado_q;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_hexa
            hexa7seg u_hexa7seg (
                .hexa    (hexa_in[gi]),
                .display (hexa_out[gi])
            );
        end
    endgenerate

    assign db_contagem      = hexa_out[0];
    assign db_memoria       = hexa_out[1];
    assign db_chaves        = hexa_out[2];
    assign db_estado        = hexa_out[3];
    assign db_acertou_errou = pronto ? hexa_out[4] : SEG_APAGADO;

endmodule

// File: tb/tb_circuito_exp3_desafio.sv
// Bench for the memory game: step-index reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized play.
module tb_circuito_exp3_desafio;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] chaves  = 4'h0;
    logic       pronto, acertou, errou, db_igual, db_iniciar;
    logic [6:0] db_contagem, db_memoria, db_chaves, db_estado, db_acertou_errou;

    circuito_exp3_desafio dut (
        .clock            (clock),
        .reset            (reset),
        .iniciar          (iniciar),
        .chaves           (chaves),
        .pronto           (pronto),
        .acertou          (acertou),
        .errou            (errou),
        .db_igual         (db_igual),
        .db_iniciar       (db_iniciar),
        .db_contagem      (db_contagem),
        .db_memoria       (db_memoria),
        .db_chaves        (db_chaves),
        .db_estado        (db_estado),
        .db_acertou_errou (db_acertou_errou)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [3:0] rom_m [16] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd1,
                               4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1, 4'd4};
    logic [6:0] seg_m [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_OK   = 2;
    localparam int M_ERR  = 3;

    // Model: m_t counts cycles since entering the run (0 = preparation),
    // then every step is three cycles: register, compare, advance.
    int         m_mode = M_IDLE;
    int         m_t    = 0;
    int         m_addr = 0;
    logic [3:0] m_keys = 4'h0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_mode = M_IDLE;
            m_t    = 0;
            m_addr = 0;
            m_keys = 4'h0;
        end else if (m_mode != M_RUN) begin
            if (iniciar) begin
                m_mode = M_RUN;
                m_t    = 0;
            end
        end else begin
            if (m_t >= 1 && (m_t - 1) % 3 == 1) begin
                if (m_keys != rom_m[m_addr]) m_mode = M_ERR;
                else if (m_addr == 15)        m_mode = M_OK;
                else                          m_t++;
            end else begin
                if (m_t >= 1 && (m_t - 1) % 3 == 0) m_keys = chaves;
                m_t++;
            end
            if (m_mode == M_RUN) m_addr = (m_t - 1) / 3;
        end
    end

    task automatic chk7(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_code();
        if (m_mode == M_IDLE) return 4'h0;
        if (m_mode == M_OK)   return 4'hA;
        if (m_mode == M_ERR)  return 4'hE;
        if (m_t == 0)         return 4'h1;
        return 4'(2 + (m_t - 1) % 3);
    endfunction

    always @(negedge clock) begin
        logic [3:0] code;
        logic [6:0] res;
        code = model_code();
        res  = (m_mode == M_OK) ? seg_m[10] : (m_mode == M_ERR) ? seg_m[14] : 7'h7F;
        chk1("pronto", pronto, m_mode == M_OK || m_mode == M_ERR);
        chk1("acertou", acertou, m_mode == M_OK);
        chk1("errou", errou, m_mode == M_ERR);
        chk1("db_igual", db_igual, m_keys == rom_m[m_addr]);
        chk1("db_iniciar", db_iniciar, iniciar);
        chk7("db_contagem", db_contagem, seg_m[m_addr]);
        chk7("db_memoria", db_memoria, seg_m[rom_m[m_addr]]);
        chk7("db_chaves", db_chaves, seg_m[m_keys]);
        chk7("db_estado", db_estado, seg_m[code]);
        chk7("db_acertou_errou", db_acertou_errou, res);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int n;
        #1 reset = 1'b0;
        #1;
        chk7("rst_estado", db_estado, 7'h40);
        chk7("rst_memoria", db_memoria, 7'h79);
        chk7("rst_blank", db_acertou_errou, 7'h7F);
        repeat (2) tick();
        reset = 1'b1;

        // idle after reset
        repeat (5) tick();
        chk7("idle_estado", db_estado, 7'h40);
        chk1("idle_pronto", pronto, 1'b0);

        // full correct run
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chaves = rom_m[m_addr];
        n = 0;
        while (!acertou && n < 100) begin
            tick();
            n++;
            chaves = rom_m[m_addr];
        end
        chkn("full_run_clocks", n, 48);
        chk1("full_acertou", acertou, 1'b1);
        chk1("full_pronto", pronto, 1'b1);
        chk7("full_contagem", db_contagem, 7'h0E);
        chk7("full_glyph", db_acertou_errou, 7'h08);

        // immediate error with keys 0000
        pulse_reset();
        tick();
        chaves  = 4'h0;
        iniciar = 1'b1;
        n = 0;
        while (!errou && n < 20) begin
            tick();
            n++;
            iniciar = 1'b0;
        end
        chkn("err_edges", n, 4);
        chk1("err_errou", errou, 1'b1);
        chk7("err_contagem", db_contagem, 7'h40);
        chk7("err_glyph", db_acertou_errou, 7'h06);

        // correct keys for 0-5, wrong at 6
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n = 0;
        while (!errou && n < 100) begin
            chaves = (m_addr < 6) ? rom_m[m_addr] : 4'h0;
            tick();
            n++;
        end
        chk1("mid_errou", errou, 1'b1);
        chk7("mid_contagem", db_contagem, 7'h02);
        chk7("mid_memoria", db_memoria, 7'h79);
        chk7("mid_chaves", db_chaves, 7'h40);

        // restart from the error state
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk7("restart_estado", db_estado, 7'h79);
        chk1("restart_pronto", pronto, 1'b0);
        chk1("restart_errou", errou, 1'b0);
        tick();
        chk7("restart_contagem", db_contagem, 7'h40);

        // reset while advancing at address 9
        n = 0;
        while (!(m_mode == M_RUN && m_t >= 1 && (m_t - 1) % 3 == 2 && m_addr == 9) && n < 100) begin
            chaves = rom_m[m_addr];
            tick();
            n++;
        end
        chk1("abort_reached", n < 100, 1'b1);
        chk7("abort_pre_estado", db_estado, 7'h19);
        chk7("abort_pre_contagem", db_contagem, 7'h10);
        reset = 1'b0;
        #1;
        chk7("abort_estado", db_estado, 7'h40);
        chk7("abort_contagem", db_contagem, 7'h40);
        chk1("abort_pronto", pronto, 1'b0);
        tick();
        reset = 1'b1;

        // randomized play
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) pulse_reset();
            iniciar = ($urandom_range(0, 7) == 0);
            chaves  = ($urandom_range(0, 19) != 0) ? rom_m[m_addr] : 4'($urandom_range(0, 15));
            tick();
        end
        iniciar = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
